// File: rtl/syn_pkg.sv
// Shared types and constants for the synapse access scheduler: FSM state
// encoding, table geometry and the synapse address former.
package syn_pkg;

    localparam int SYN_LANES  = 4;
    localparam int SYN_WORDS  = 32;
    localparam int SYN_RD_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SERVE,
        ST_RD_WAIT,
        ST_TURN,
        ST_FLUSH
    } syn_state_e;

    // Byte-lane address of a table word: synapse index 4*word + lane.
    function automatic logic [15:0] syn_iaddr_of(input logic [15:0] word, input logic [1:0] lane);
        return (word << 2) | {14'b0, lane};
    endfunction

endpackage

// File: rtl/syn_access_sched_if.sv
// Bus between the access scheduler (master) and one synapse instance (slave).
interface syn_access_sched_if;
    logic [15:0] iaddr;
    logic [31:0] wdata;
    logic        w_en;
    logic        r_en;
    logic        kill;
    logic [15:0] weight;

    modport master (output iaddr, wdata, w_en, r_en, kill, input weight);
    modport slave  (input iaddr, wdata, w_en, r_en, kill, output weight);
endinterface

// File: rtl/syn_rr_arb.sv
// Two-requester round-robin arbiter; req[0] (spike) wins first after reset and
// the pointer only moves when both requesters contend for a grant.
module syn_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                        ptr <= 1'b0;
        else if (en && req == 2'b11)    ptr <= ~ptr;
    end
endmodule

// File: rtl/syn_access_sched.sv
// Sequences table load, spike reads and STDP write-backs onto one synapse.
// Optional perf counters: define SYN_ACCESS_SCHED_PERF_EN.
//
// state    | meaning
// IDLE     | table word handshake (load_ready)
// LOAD     | four byte-lane writes of the captured word
// SERVE    | table loaded, arbitrate spike reads / STDP writes
// RD_WAIT  | read in flight, down-count synapse latency
// TURN     | one-cycle bubble after a write
// FLUSH    | synapse kill, held while flush is high
module syn_access_sched
    import syn_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int WORDS  = SYN_WORDS,
    parameter int RD_LAT = SYN_RD_LAT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic              load_done,
    input  logic              spk_valid,
    input  logic [ADDR_W-1:0] spk_addr,
    output logic              spk_ready,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [15:0]       rsp_weight,
    input  logic              stdp_valid,
    input  logic [ADDR_W-1:0] stdp_addr,
    input  logic [7:0]        stdp_weight,
    output logic              stdp_ready,
    input  logic              flush,
    output logic              busy,
    syn_access_sched_if.master syn
`ifdef SYN_ACCESS_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_rd,
    output logic [CNT_W-1:0]  perf_wr,
    output logic [CNT_W-1:0]  perf_stall
`endif
);
    localparam int WW = $clog2(WORDS);

    if (WORDS * SYN_LANES != (1 << ADDR_W) || CNT_W < 1) begin : g_cfg_check
        $error("syn_access_sched: WORDS, ADDR_W and CNT_W are inconsistent");
    end

    syn_state_e        state, state_n;
    logic [WW-1:0]     word_q;
    logic [1:0]        lane_q;
    logic [31:0]       cap_q;
    logic [3:0]        rd_cnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              load_done_q;
    logic              rdy_arm_q;
    logic [15:0]       iaddr_q, iaddr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic              w_en, r_en, kill;
    logic              arb_en;
    logic [1:0]        gnt;

    assign arb_en = (state == ST_SERVE) && !flush;

    syn_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({stdp_valid, spk_valid}),
        .gnt (gnt)
    );

    always_comb begin
        state_n    = state;
        iaddr_n    = iaddr_q;
        wdata_n    = wdata_q;
        w_en       = 1'b0;
        r_en       = 1'b0;
        kill       = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy       = 1'b0;
                load_ready = rdy_arm_q && !flush;
                if (load_valid && load_ready) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                if (!flush) begin
                    w_en    = 1'b1;
                    iaddr_n = syn_iaddr_of(16'(word_q), lane_q);
                    wdata_n = cap_q;
                end
                if (lane_q == 2'd3)
                    state_n = (word_q == WW'(WORDS - 1)) ? ST_SERVE : ST_IDLE;
            end
            ST_SERVE: begin
                busy = spk_valid || stdp_valid;
                if (gnt[0]) begin
                    r_en    = 1'b1;
                    iaddr_n = 16'(spk_addr);
                    state_n = ST_RD_WAIT;
                end else if (gnt[1]) begin
                    w_en    = 1'b1;
                    iaddr_n = 16'(stdp_addr);
                    wdata_n = {4{stdp_weight}};
                    state_n = ST_TURN;
                end
            end
            ST_RD_WAIT: if (rd_cnt_q == 4'd0) state_n = ST_SERVE;
            ST_TURN:    state_n = ST_SERVE;
            ST_FLUSH: begin
                kill    = 1'b1;
                state_n = ST_IDLE;
            end
            default:    state_n = ST_IDLE;
        endcase
        if (flush) state_n = ST_FLUSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_q      <= '0;
            lane_q      <= '0;
            cap_q       <= '0;
            rd_cnt_q    <= '0;
            rd_addr_q   <= '0;
            load_done_q <= 1'b0;
            rdy_arm_q   <= 1'b0;
            iaddr_q     <= '0;
            wdata_q     <= '0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_weight  <= '0;
        end else begin
            state     <= state_n;
            rdy_arm_q <= 1'b1;
            iaddr_q   <= iaddr_n;
            wdata_q   <= wdata_n;
            rsp_valid <= 1'b0;
            if (flush) begin
                word_q      <= '0;
                lane_q      <= '0;
                load_done_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (load_valid && load_ready) begin
                        cap_q  <= load_data;
                        lane_q <= '0;
                    end
                    ST_LOAD: begin
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            word_q <= word_q + 1'b1;
                            if (word_q == WW'(WORDS - 1)) load_done_q <= 1'b1;
                        end
                    end
                    ST_SERVE: if (gnt[0]) begin
                        rd_addr_q <= spk_addr;
                        rd_cnt_q  <= 4'(RD_LAT - 1);
                    end
                    ST_RD_WAIT: begin
                        if (rd_cnt_q == 4'd0) begin
                            rsp_valid  <= 1'b1;
                            rsp_addr   <= rd_addr_q;
                            rsp_weight <= syn.weight;
                        end else begin
                            rd_cnt_q <= rd_cnt_q - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load_done  = load_done_q;
    assign spk_ready  = gnt[0];
    assign stdp_ready = gnt[1];
    assign syn.iaddr  = iaddr_n;
    assign syn.wdata  = wdata_n;
    assign syn.w_en   = w_en;
    assign syn.r_en   = r_en;
    assign syn.kill   = kill;

`ifdef SYN_ACCESS_SCHED_PERF_EN
    logic stall;
    assign stall = load_done_q && ((spk_valid && !spk_ready) || (stdp_valid && !stdp_ready));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            perf_rd    <= '0;
            perf_wr    <= '0;
            perf_stall <= '0;
        end else begin
            if (gnt[0] && !(&perf_rd))    perf_rd    <= perf_rd + 1'b1;
            if (gnt[1] && !(&perf_wr))    perf_wr    <= perf_wr + 1'b1;
            if (stall && !(&perf_stall))  perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule
